// File: rtl/accum_run_ctrl.sv
// Button front end for the accumulator: synchronizes and debounces the Run and
// Clear keys, emits one registered strobe per press and counts accepted Runs.
module accum_run_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run_In,
    input  logic             Clear_In,
    output logic             Run_Pulse,
    output logic             Clear_Pulse,
    output logic             Busy,
    output logic [CNT_W-1:0] Press_Count
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_FIRE,
        S_HOLD,
        S_RELEASE_WAIT
    } state_t;

    // Bit 0 = Run, bit 1 = Clear, both before and after synchronization.
    logic [1:0] btn_raw;
    logic [1:0] btn_sync;

    assign btn_raw = {Clear_In, Run_In};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], btn_raw[gi]};
                end
            end

            assign btn_sync[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    logic rs;
    logic cs;
    logic sel_btn;

    assign rs = btn_sync[0];
    assign cs = btn_sync[1];

    state_t           state_q, state_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             run_pulse_q, clear_pulse_q, busy_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fire_d;

    assign sel_btn = sel_q ? cs : rs;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    state_d = S_PRESS_WAIT;
                    sel_d   = 1'b1;
                    cnt_d   = '0;
                end else if (rs) begin
                    state_d = S_PRESS_WAIT;
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!sel_btn) begin
                    state_d = S_IDLE;
                end else if (!sel_q && cs) begin
                    // A Clear arriving while a Run is still settling takes over.
                    sel_d = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIRE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_FIRE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!rs && !cs) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (rs || cs) begin
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes and the counter are loaded from the next state so they line up with FIRE.
    assign fire_d  = (state_d == S_FIRE);
    assign count_d = !fire_d ? count_q : (sel_d ? '0 : count_q + CNT_W'(1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sel_q         <= 1'b0;
            run_pulse_q   <= 1'b0;
            clear_pulse_q <= 1'b0;
            busy_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            run_pulse_q   <= fire_d && !sel_d;
            clear_pulse_q <= fire_d && sel_d;
            busy_q        <= (state_d != S_IDLE);
            count_q       <= count_d;
        end
    end

    assign Run_Pulse   = run_pulse_q;
    assign Clear_Pulse = clear_pulse_q;
    assign Busy        = busy_q;
    assign Press_Count = count_q;

endmodule

// File: tb/tb_accum_run_ctrl.sv
// Directed bench for accum_run_ctrl: a press/release acceptance model checked every
// cycle, plus literal latency and count expectations for each scenario.
module tb_accum_run_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Run_In;
    logic          Clear_In;
    logic          Run_Pulse;
    logic          Clear_Pulse;
    logic          Busy;
    logic [CW-1:0] Press_Count;

    accum_run_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .Clk        (clk),
        .Reset      (Reset),
        .Run_In     (Run_In),
        .Clear_In   (Clear_In),
        .Run_Pulse  (Run_Pulse),
        .Clear_Pulse(Clear_Pulse),
        .Busy       (Busy),
        .Press_Count(Press_Count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int nchk   = 0;
    int cyc    = 0;
    int run_cnt = 0;
    int clr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the key is seen through a SYNC-deep delay; a press is accepted after
    // DEB+1 consecutive high samples of the chosen key, and the controller is free
    // again after DEB+1 consecutive samples with both keys low once the strobe is out.
    // Phases: 0 free, 1 press settling, 2 strobe cycle, 3 latched until released.
    typedef struct packed {
        int            ph;
        int            n;
        bit            sel;
        bit            run;
        bit            clr;
        bit [CW-1:0]   cnt;
        bit [SYNC-1:0] dr;
        bit [SYNC-1:0] dc;
    } model_t;

    model_t mdl = '0;

    function automatic model_t step(input model_t m, input bit ri, input bit ci);
        model_t o = m;
        bit r = m.dr[SYNC-1];
        bit c = m.dc[SYNC-1];
        o.dr  = {m.dr[SYNC-2:0], ri};
        o.dc  = {m.dc[SYNC-2:0], ci};
        o.run = 1'b0;
        o.clr = 1'b0;
        if (m.ph == 0) begin
            if (c || r) begin
                o.ph = 1; o.sel = c; o.n = 1;
            end
        end else if (m.ph == 1) begin
            if (!(m.sel ? c : r)) begin
                o.ph = 0;
            end else if (!m.sel && c) begin
                o.sel = 1'b1; o.n = 1;
            end else begin
                o.n = m.n + 1;
                if (o.n == DEB + 1) begin
                    o.ph = 2;
                    if (m.sel) begin o.clr = 1'b1; o.cnt = '0; end
                    else       begin o.run = 1'b1; o.cnt = m.cnt + 1'b1; end
                end
            end
        end else if (m.ph == 2) begin
            o.ph = 3; o.n = 0;
        end else begin
            o.n = (r || c) ? 0 : m.n + 1;
            if (o.n == DEB + 1) o.ph = 0;
        end
        return o;
    endfunction

    initial forever begin
        @(posedge clk or posedge Reset);
        if (Reset) mdl = '0;
        else       mdl = step(mdl, Run_In, Clear_In);
    end

    initial forever begin
        @(negedge clk);
        chk("cycle_outputs",
            32'({Run_Pulse, Clear_Pulse, Busy, Press_Count}),
            32'({mdl.run, mdl.clr, (mdl.ph != 0), mdl.cnt}));
        if (Run_Pulse)   run_cnt++;
        if (Clear_Pulse) clr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, nchk + 1);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk) Reset = 1'b1;
        @(negedge clk) Reset = 1'b0;
    endtask

    // which: 0 Run_Pulse high, 1 Clear_Pulse high, 2 Busy low; lat=-1 on timeout.
    task automatic wait_for(input int which, input int ref_cyc, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && Run_Pulse) || (which == 1 && Clear_Pulse) ||
                (which == 2 && !Busy)) begin
                lat = cyc - ref_cyc;
                break;
            end
        end
    endtask

    task automatic press(input bit clr, input int hold, input int rel);
        @(negedge clk);
        if (clr) Clear_In = 1'b1; else Run_In = 1'b1;
        repeat (hold) @(negedge clk);
        Run_In   = 1'b0;
        Clear_In = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    int e, r, lat, r0, c0;

    initial begin
        Reset    = 1'b1;
        Run_In   = 1'b0;
        Clear_In = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(Busy), 0);
        chk("reset_count", 32'(Press_Count), 0);
        chk("reset_strobes", 32'({Run_Pulse, Clear_Pulse}), 0);
        Reset = 1'b0;

        // 1: clean press held 20 cycles
        do_reset();
        r0 = run_cnt;
        @(negedge clk) Run_In = 1'b1;
        @(posedge clk); #1 e = cyc;
        wait_for(0, e, lat);
        chk("t1_press_latency", lat, 6);
        chk("t1_count", 32'(Press_Count), 1);
        repeat (14) @(negedge clk);
        Run_In = 1'b0;
        @(posedge clk); #1 r = cyc;
        chk("t1_busy_held", 32'(Busy), 1);
        wait_for(2, r, lat);
        chk("t1_release_latency", lat, 6);
        @(negedge clk);
        chk("t1_pulses", run_cnt - r0, 1);

        // 2: bouncing press then stable high
        do_reset();
        r0 = run_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) Run_In = 1'b1;
            repeat (2) @(negedge clk);
            Run_In = 1'b0;
            repeat (1) @(negedge clk);
        end
        Run_In = 1'b1;
        repeat (10) @(negedge clk);
        Run_In = 1'b0;
        repeat (12) @(negedge clk);
        chk("t2_pulses", run_cnt - r0, 1);
        chk("t2_count", 32'(Press_Count), 1);

        // 3: three-cycle glitch
        do_reset();
        r0 = run_cnt;
        press(1'b0, 3, 10);
        chk("t3_pulses", run_cnt - r0, 0);
        chk("t3_count", 32'(Press_Count), 0);
        chk("t3_idle", 32'(Busy), 0);

        // 4: count to 5, then both keys together
        do_reset();
        for (int i = 0; i < 5; i++) press(1'b0, 8, 10);
        chk("t4_count5", 32'(Press_Count), 5);
        r0 = run_cnt;
        c0 = clr_cnt;
        @(negedge clk);
        Run_In   = 1'b1;
        Clear_In = 1'b1;
        repeat (10) @(negedge clk);
        Run_In   = 1'b0;
        Clear_In = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_clear_pulses", clr_cnt - c0, 1);
        chk("t4_run_pulses", run_cnt - r0, 0);
        chk("t4_count0", 32'(Press_Count), 0);

        // 7: Clear arriving while a Run press is still settling
        do_reset();
        press(1'b0, 8, 10);
        r0 = run_cnt;
        c0 = clr_cnt;
        @(negedge clk) Run_In = 1'b1;
        repeat (2) @(negedge clk);
        Clear_In = 1'b1;
        @(posedge clk); #1 e = cyc;
        wait_for(1, e, lat);
        chk("t7_clear_latency", lat, 6);
        repeat (8) @(negedge clk);
        Run_In   = 1'b0;
        Clear_In = 1'b0;
        repeat (12) @(negedge clk);
        chk("t7_clear_pulses", clr_cnt - c0, 1);
        chk("t7_run_pulses", run_cnt - r0, 0);
        chk("t7_count", 32'(Press_Count), 0);

        // 5: wrap after 256 presses
        do_reset();
        r0 = run_cnt;
        for (int i = 0; i < 256; i++) begin
            press(1'b0, 8, 10);
            if (i == 254) chk("t5_count255", 32'(Press_Count), 255);
        end
        chk("t5_count_wrap", 32'(Press_Count), 0);
        chk("t5_pulses", run_cnt - r0, 256);

        // 6: reset during settling and during the strobe, key held throughout
        do_reset();
        r0 = run_cnt;
        @(negedge clk) Run_In = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_busy_pending", 32'(Busy), 1);
        Reset = 1'b1;
        #1;
        chk("t6_rst1_outputs", 32'({Run_Pulse, Clear_Pulse, Busy, Press_Count}), 0);
        @(negedge clk) Reset = 1'b0;
        @(posedge clk); #1 e = cyc;
        wait_for(0, e, lat);
        chk("t6_refire_latency", lat, 6);
        #1 Reset = 1'b1;
        #1;
        chk("t6_rst2_outputs", 32'({Run_Pulse, Clear_Pulse, Busy, Press_Count}), 0);
        @(negedge clk) Reset = 1'b0;
        @(posedge clk); #1 e = cyc;
        wait_for(0, e, lat);
        chk("t6_refire2_latency", lat, 6);
        repeat (4) @(negedge clk);
        Run_In = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_pulses", run_cnt - r0, 1);
        chk("t6_count", 32'(Press_Count), 1);
        chk("t6_idle", 32'(Busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, nchk);
        $finish;
    end

endmodule
